// File: rtl/obc_axi_pkg.sv
// Shared AXI4 encodings and write-master FSM state type for the OBC DDR stream writer.
package obc_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_FIN  = 3'd4
    } wr_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/obc_sync_fifo.sv
// Single-clock FIFO with fall-through read port and occupancy count.
// A pop and a push in the same cycle are both honoured even when full.
module obc_sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_do_s;
    logic              pop_do_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign pop_do_s  = pop && !empty;
    assign push_do_s = push && (!full || pop_do_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; not reset, the head is only consumed when count is non-zero.
    always_ff @(posedge clk) begin
        if (push_do_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_do_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_do_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_do_s, pop_do_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/obc_ddr_stream_writer.sv
// AXI-Stream to AXI4 INCR-burst write master feeding the DDR4 path; one burst in flight.
// Optional statistics outputs are built when OBC_DDR_WR_STATS_EN is defined.
module obc_ddr_stream_writer
    import obc_axi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ctrl_start,
    input  logic [ADDR_W-1:0]   ctrl_addr,
    input  logic [23:0]         ctrl_len,
    output logic                ctrl_busy,
    output logic                ctrl_done,
    output logic                ctrl_err,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
`ifdef OBC_DDR_WR_STATS_EN
    ,
    output logic [15:0]         stat_bursts,
    output logic [31:0]         stat_stalls
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    wr_state_e          state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  awaddr_r;
    logic [7:0]         awlen_r;
    logic [2:0]         awsize_r;
    logic [1:0]         awburst_r;
    logic               awvalid_r;
    logic               bready_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [23:0]        len_r;
    logic [23:0]        remaining_r;
    logic [23:0]        accepted_r;
    logic [CNT_W-1:0]   beat_r;

    logic [CNT_W-1:0]   burst_beats_s;
    logic [DATA_W-1:0]  fifo_rdata_s;
    logic [FCNT_W-1:0]  fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               s_tready_s;
    logic               push_s;
    logic               wvalid_s;
    logic               w_fire_s;
    logic               wlast_s;
    logic               fifo_ready_s;
    logic               b_fire_s;
    logic               start_ok_s;

    // Size of the burst about to be issued: a full burst, or the short tail.
    always_comb begin
        if (remaining_r >= 24'(BURST_LEN)) begin
            burst_beats_s = CNT_W'(BURST_LEN);
        end else begin
            burst_beats_s = remaining_r[CNT_W-1:0];
        end
    end

    // Stream words past the programmed length are never accepted.
    assign s_tready_s   = !fifo_full_s && busy_r && (accepted_r < len_r);
    assign push_s       = s_tvalid && s_tready_s;
    assign wvalid_s     = (state_r == ST_W) && !fifo_empty_s;
    assign w_fire_s     = wvalid_s && m_wready;
    assign wlast_s      = (beat_r == (burst_beats_s - CNT_W'(1)));
    assign fifo_ready_s = (32'(fifo_count_s) >= 32'(burst_beats_s));
    assign b_fire_s     = (state_r == ST_B) && bready_r && m_bvalid;
    assign start_ok_s   = (state_r == ST_IDLE) && ctrl_start;

    obc_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (FCNT_W)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push   (push_s),
        .wdata  (s_tdata),
        .pop    (w_fire_s),
        .rdata  (fifo_rdata_s),
        .count  (fifo_count_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Transfer sequencer: AW -> W -> B per burst, looping until the length is exhausted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            awaddr_r    <= {ADDR_W{1'b0}};
            awlen_r     <= 8'd0;
            awsize_r    <= 3'd0;
            awburst_r   <= 2'd0;
            awvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            len_r       <= 24'd0;
            remaining_r <= 24'd0;
            accepted_r  <= 24'd0;
            beat_r      <= {CNT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (push_s) begin
                accepted_r <= accepted_r + 24'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        err_r       <= 1'b0;
                        accepted_r  <= 24'd0;
                        addr_r      <= ctrl_addr;
                        len_r       <= ctrl_len;
                        remaining_r <= ctrl_len;
                        if (ctrl_len == 24'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= ST_AW;
                        end
                    end
                end
                ST_AW: begin
                    // Address is only offered once the whole burst is already buffered.
                    if (!awvalid_r) begin
                        if (fifo_ready_s) begin
                            awvalid_r <= 1'b1;
                            awaddr_r  <= addr_r;
                            awlen_r   <= 8'(burst_beats_s - CNT_W'(1));
                            awsize_r  <= AXI_SIZE_8B;
                            awburst_r <= AXI_BURST_INCR;
                        end
                    end else if (m_awready) begin
                        awvalid_r <= 1'b0;
                        beat_r    <= {CNT_W{1'b0}};
                        state_r   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_fire_s) begin
                        if (wlast_s) begin
                            bready_r <= 1'b1;
                            state_r  <= ST_B;
                        end else begin
                            beat_r <= beat_r + CNT_W'(1);
                        end
                    end
                end
                ST_B: begin
                    if (b_fire_s) begin
                        bready_r    <= 1'b0;
                        err_r       <= err_r | resp_is_err(m_bresp);
                        addr_r      <= addr_r + ADDR_W'({burst_beats_s, 3'b000});
                        remaining_r <= remaining_r - 24'(burst_beats_s);
                        if (remaining_r == 24'(burst_beats_s)) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_FIN;
                        end else begin
                            state_r <= ST_AW;
                        end
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl_busy = busy_r;
    assign ctrl_done = done_r;
    assign ctrl_err  = err_r;
    assign s_tready  = s_tready_s;
    assign m_awaddr  = awaddr_r;
    assign m_awlen   = awlen_r;
    assign m_awsize  = awsize_r;
    assign m_awburst = awburst_r;
    assign m_awvalid = awvalid_r;
    assign m_wvalid  = wvalid_s;
    assign m_wlast   = wvalid_s && wlast_s;
    assign m_wdata   = wvalid_s ? fifo_rdata_s : {DATA_W{1'b0}};
    assign m_wstrb   = wvalid_s ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
    assign m_bready  = bready_r;

`ifdef OBC_DDR_WR_STATS_EN
    logic [15:0] stat_bursts_r;
    logic [31:0] stat_stalls_r;

    // Saturating burst and W-stall counters, cleared by each accepted start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_bursts_r <= 16'd0;
            stat_stalls_r <= 32'd0;
        end else if (start_ok_s) begin
            stat_bursts_r <= 16'd0;
            stat_stalls_r <= 32'd0;
        end else begin
            if (b_fire_s && (stat_bursts_r != 16'hFFFF)) begin
                stat_bursts_r <= stat_bursts_r + 16'd1;
            end
            if (wvalid_s && !m_wready && (stat_stalls_r != 32'hFFFF_FFFF)) begin
                stat_stalls_r <= stat_stalls_r + 32'd1;
            end
        end
    end

    assign stat_bursts = stat_bursts_r;
    assign stat_stalls = stat_stalls_r;
`else
    // Without statistics the start qualifier has no further consumer.
    logic start_ok_unused_s;
    assign start_ok_unused_s = start_ok_s;
`endif

endmodule
